// File: rtl/fc_pkg.sv
// Shared constants, one-hot state encoding and the score saturation helper for the FC3 classifier.
package fc_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 32;
  localparam int INPUT_MAP  = 84;
  localparam int OUTPUT_MAP = 10;

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_BIAS  = 6'b000010;
  localparam logic [5:0] ST_MAC   = 6'b000100;
  localparam logic [5:0] ST_DRAIN = 6'b001000;
  localparam logic [5:0] ST_WRITE = 6'b010000;
  localparam logic [5:0] ST_DONE  = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE  = ST_IDLE,
    S_BIAS  = ST_BIAS,
    S_MAC   = ST_MAC,
    S_DRAIN = ST_DRAIN,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } state_t;

  function automatic logic signed [DATA_WIDTH-1:0] sat16(input logic signed [ACC_WIDTH-1:0] v);
    if (v > 32767)
      return 16'sh7FFF;
    else if (v < -32768)
      return 16'sh8000;
    else
      return v[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/fc3_classifier_argmax.sv
// Running argmax over the class scores; index 0 always seeds, later scores must be strictly greater.
module argmax_tracker
  import fc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         valid,
  input  logic [3:0]                   idx,
  input  logic signed [DATA_WIDTH-1:0] score,
  output logic [3:0]                   max_idx,
  output logic signed [DATA_WIDTH-1:0] max_val
);
  logic [3:0]                   max_idx_q, max_idx_d;
  logic signed [DATA_WIDTH-1:0] max_val_q, max_val_d;

  always_comb begin
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (clr) begin
      max_idx_d = '0;
      max_val_d = '0;
    end else if (valid && (idx == 4'd0 || score > max_val_q)) begin
      max_idx_d = idx;
      max_val_d = score;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  assign max_idx = max_idx_q;
  assign max_val = max_val_q;
endmodule

// File: rtl/fc3_classifier.sv
// LeNet-5 output layer: 84x10 dot products plus bias into a score RAM, argmax reported with done.
// Define FC3_SCORE_SAT_EN to clamp scores to 16 bits; otherwise the low 16 accumulator bits are kept.
module fc3_classifier
  import fc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [6:0]                   in_read_addr,
  input  logic signed [DATA_WIDTH-1:0] in_read_data,
  output logic [9:0]                   weight_addr,
  input  logic signed [DATA_WIDTH-1:0] weight_data,
  output logic [3:0]                   bias_addr,
  input  logic signed [DATA_WIDTH-1:0] bias_data,
  output logic                         score_write_ena,
  output logic [3:0]                   score_write_addr,
  output logic signed [DATA_WIDTH-1:0] score_write_data,
  output logic [3:0]                   class_idx,
  output logic                         class_valid,
  output logic                         done
);
  state_t                       state_q, state_d;
  logic [3:0]                   j_q, j_d;
  logic [6:0]                   in_read_addr_q, in_read_addr_d;
  logic [9:0]                   weight_addr_q, weight_addr_d;
  logic [3:0]                   bias_addr_q, bias_addr_d;
  logic                         drain_q, drain_d;
  logic                         dat_vld_q, dat_vld_d;
  logic                         bias_vld_q, bias_vld_d;
  logic                         prod_vld_q, prod_vld_d;
  logic signed [ACC_WIDTH-1:0]  prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         score_write_ena_q, score_write_ena_d;
  logic [3:0]                   score_write_addr_q, score_write_addr_d;
  logic signed [DATA_WIDTH-1:0] score_write_data_q, score_write_data_d;
  logic [3:0]                   class_idx_q, class_idx_d;
  logic                         class_valid_q, class_valid_d;
  logic                         done_q, done_d;
  logic                         trk_clr;
  logic [3:0]                   max_idx;
  logic signed [DATA_WIDTH-1:0] max_val_unused;
  logic signed [DATA_WIDTH-1:0] score_w;

`ifdef FC3_SCORE_SAT_EN
  assign score_w = sat16(acc_d);
`else
  assign score_w = acc_d[DATA_WIDTH-1:0];
`endif

  always_comb begin
    state_d            = state_q;
    j_d                = j_q;
    in_read_addr_d     = '0;
    weight_addr_d      = '0;
    bias_addr_d        = '0;
    drain_d            = drain_q;
    score_write_ena_d  = 1'b0;
    score_write_addr_d = '0;
    score_write_data_d = '0;
    class_idx_d        = class_idx_q;
    class_valid_d      = class_valid_q;
    done_d             = done_q;
    trk_clr            = 1'b0;

    // Read data lands one cycle after the address, the product one cycle later.
    dat_vld_d  = (state_q == S_MAC);
    bias_vld_d = (state_q == S_BIAS);
    prod_vld_d = dat_vld_q;
    prod_d     = dat_vld_q ? ACC_WIDTH'(in_read_data) * ACC_WIDTH'(weight_data) : prod_q;
    if (bias_vld_q)
      acc_d = ACC_WIDTH'(bias_data);
    else if (prod_vld_q)
      acc_d = acc_q + (prod_q >>> FRAC_BITS);
    else
      acc_d = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_BIAS;
          trk_clr = 1'b1;
        end
      end
      S_BIAS: begin
        state_d       = S_MAC;
        weight_addr_d = 10'(j_q) * 10'(INPUT_MAP);
      end
      S_MAC: begin
        if (in_read_addr_q == 7'(INPUT_MAP - 1)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          in_read_addr_d = in_read_addr_q + 7'd1;
          weight_addr_d  = weight_addr_q + 10'd1;
        end
      end
      S_DRAIN: begin
        // Score is registered from acc_d so it includes the final product.
        if (drain_q) begin
          state_d            = S_WRITE;
          score_write_ena_d  = 1'b1;
          score_write_addr_d = j_q;
          score_write_data_d = score_w;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_WRITE: begin
        acc_d = '0;
        if (j_q == 4'(OUTPUT_MAP - 1)) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          class_valid_d = 1'b1;
          class_idx_d   = max_idx;
        end else begin
          state_d     = S_BIAS;
          j_d         = j_q + 4'd1;
          bias_addr_d = j_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d            = S_IDLE;
      j_d                = '0;
      in_read_addr_d     = '0;
      weight_addr_d      = '0;
      bias_addr_d        = '0;
      drain_d            = 1'b0;
      dat_vld_d          = 1'b0;
      bias_vld_d         = 1'b0;
      prod_vld_d         = 1'b0;
      acc_d              = '0;
      score_write_ena_d  = 1'b0;
      score_write_addr_d = '0;
      score_write_data_d = '0;
      class_idx_d        = '0;
      class_valid_d      = 1'b0;
      done_d             = 1'b0;
      trk_clr            = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      j_q                <= '0;
      in_read_addr_q     <= '0;
      weight_addr_q      <= '0;
      bias_addr_q        <= '0;
      drain_q            <= 1'b0;
      dat_vld_q          <= 1'b0;
      bias_vld_q         <= 1'b0;
      prod_vld_q         <= 1'b0;
      prod_q             <= '0;
      acc_q              <= '0;
      score_write_ena_q  <= 1'b0;
      score_write_addr_q <= '0;
      score_write_data_q <= '0;
      class_idx_q        <= '0;
      class_valid_q      <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      j_q                <= j_d;
      in_read_addr_q     <= in_read_addr_d;
      weight_addr_q      <= weight_addr_d;
      bias_addr_q        <= bias_addr_d;
      drain_q            <= drain_d;
      dat_vld_q          <= dat_vld_d;
      bias_vld_q         <= bias_vld_d;
      prod_vld_q         <= prod_vld_d;
      prod_q             <= prod_d;
      acc_q              <= acc_d;
      score_write_ena_q  <= score_write_ena_d;
      score_write_addr_q <= score_write_addr_d;
      score_write_data_q <= score_write_data_d;
      class_idx_q        <= class_idx_d;
      class_valid_q      <= class_valid_d;
      done_q             <= done_d;
    end
  end

  // Fed with the next-cycle write so the argmax is settled by the time WRITE decides DONE.
  argmax_tracker u_argmax (
    .clk     (clk),
    .rst     (rst),
    .clr     (trk_clr),
    .valid   (score_write_ena_d),
    .idx     (score_write_addr_d),
    .score   (score_write_data_d),
    .max_idx (max_idx),
    .max_val (max_val_unused)
  );

  assign in_read_addr     = in_read_addr_q;
  assign weight_addr      = weight_addr_q;
  assign bias_addr        = bias_addr_q;
  assign score_write_ena  = score_write_ena_q;
  assign score_write_addr = score_write_addr_q;
  assign score_write_data = score_write_data_q;
  assign class_idx        = class_idx_q;
  assign class_valid      = class_valid_q;
  assign done             = done_q;
endmodule

// File: tb/tb_fc3_classifier.sv
// Bench for fc3_classifier: RAM models, arithmetic reference model, per-cycle output monitor.
module tb_fc3_classifier;
  logic        clk;
  logic        rst;
  logic        en;
  logic [6:0]  in_read_addr;
  logic [15:0] in_read_data;
  logic [9:0]  weight_addr;
  logic [15:0] weight_data;
  logic [3:0]  bias_addr;
  logic [15:0] bias_data;
  logic        score_write_ena;
  logic [3:0]  score_write_addr;
  logic [15:0] score_write_data;
  logic [3:0]  class_idx;
  logic        class_valid;
  logic        done;

  logic [15:0] act_mem [128];
  logic [15:0] w_mem   [1024];
  logic [15:0] b_mem   [16];
  logic [15:0] exp_score [16];
  logic [15:0] cap_score [16];
  logic [3:0]  exp_idx;
  int          n_checks;
  int          n_errors;
  int          wr_cnt;
  int          cyc;

  fc3_classifier dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .in_read_addr     (in_read_addr),
    .in_read_data     (in_read_data),
    .weight_addr      (weight_addr),
    .weight_data      (weight_data),
    .bias_addr        (bias_addr),
    .bias_data        (bias_data),
    .score_write_ena  (score_write_ena),
    .score_write_addr (score_write_addr),
    .score_write_data (score_write_data),
    .class_idx        (class_idx),
    .class_valid      (class_valid),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs with one cycle of read latency.
  always @(posedge clk) begin
    in_read_data <= act_mem[in_read_addr];
    weight_data  <= w_mem[weight_addr];
    bias_data    <= b_mem[bias_addr];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic void run_model();
    int acc;
    int p;
    logic [15:0] s;
    logic [15:0] best;
    best = '0;
    for (int j = 0; j < 10; j++) begin
      acc = int'($signed(b_mem[j]));
      for (int k = 0; k < 84; k++) begin
        p = int'($signed(act_mem[k])) * int'($signed(w_mem[j*84+k]));
        acc += p >>> 8;
      end
`ifdef FC3_SCORE_SAT_EN
      if (acc > 32767) s = 16'h7FFF;
      else if (acc < -32768) s = 16'h8000;
      else s = acc[15:0];
`else
      s = acc[15:0];
`endif
      exp_score[j] = s;
      if (j == 0 || $signed(s) > $signed(best)) begin
        best    = s;
        exp_idx = 4'(j);
      end
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst || !en) begin
        wr_cnt = 0;
      end else begin
        if (score_write_ena) begin
          chk("write_order", 32'(score_write_addr), wr_cnt);
          chk("score", score_write_data, exp_score[score_write_addr]);
          cap_score[score_write_addr] = score_write_data;
          wr_cnt++;
        end
        if (done) begin
          chk("class_valid_in_done", class_valid, 1);
          chk("class_idx", class_idx, exp_idx);
        end else begin
          chk("class_valid_outside_done", class_valid, 0);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_read_addr"}, in_read_addr, 0);
    chk({tag, "_weight_addr"}, weight_addr, 0);
    chk({tag, "_bias_addr"}, bias_addr, 0);
    chk({tag, "_score_write_ena"}, score_write_ena, 0);
    chk({tag, "_score_write_addr"}, score_write_addr, 0);
    chk({tag, "_score_write_data"}, score_write_data, 0);
    chk({tag, "_class_idx"}, class_idx, 0);
    chk({tag, "_class_valid"}, class_valid, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Raise en and wait for done; DONE is due 880 cycles after leaving IDLE.
  task automatic run_once();
    for (int j = 0; j < 16; j++) cap_score[j] = 16'hDEAD;
    @(negedge clk);
    en  = 1'b1;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, 881);
    chk("write_count", wr_cnt, 10);
    repeat (3) @(negedge clk);
  endtask

  task automatic drop_en();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_low_done", done, 0);
    chk("en_low_class_valid", class_valid, 0);
    @(negedge clk);
  endtask

  task automatic load_test1();
    for (int k = 0; k < 84; k++) act_mem[k] = 16'h0000;
    for (int i = 0; i < 840; i++) w_mem[i] = 16'($urandom);
    for (int j = 0; j < 10; j++) b_mem[j] = 16'(j * 256);
    run_model();
  endtask

  task automatic check_test1(input string tag);
    for (int j = 0; j < 10; j++) chk({tag, "_score"}, cap_score[j], 16'(j * 256));
    chk({tag, "_class_idx"}, class_idx, 9);
  endtask

  initial begin
    logic [15:0] t4_exp;
    n_checks = 0;
    n_errors = 0;
    wr_cnt   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    for (int i = 0; i < 128; i++) act_mem[i] = '0;
    for (int i = 0; i < 1024; i++) w_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      b_mem[i]     = '0;
      exp_score[i] = '0;
      cap_score[i] = '0;
    end
    exp_idx = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero activations, ramped biases.
    load_test1();
    run_once();
    check_test1("t1");
    drop_en();

    // Only class 3 has non-zero weights.
    for (int k = 0; k < 84; k++) act_mem[k] = 16'h0100;
    for (int i = 0; i < 840; i++) w_mem[i] = (i / 84 == 3) ? 16'h0100 : 16'h0000;
    for (int j = 0; j < 10; j++) b_mem[j] = 16'h0000;
    run_model();
    run_once();
    for (int j = 0; j < 10; j++) chk("t2_score", cap_score[j], (j == 3) ? 16'h5400 : 16'h0000);
    chk("t2_class_idx", class_idx, 3);
    drop_en();

    // Equal scores everywhere: lowest index wins.
    for (int i = 0; i < 840; i++) w_mem[i] = 16'h0000;
    for (int j = 0; j < 10; j++) b_mem[j] = 16'h0500;
    run_model();
    run_once();
    for (int j = 0; j < 10; j++) chk("t3_score", cap_score[j], 16'h0500);
    chk("t3_class_idx", class_idx, 0);

    // en dropped in DONE, then raised again for a full recompute.
    drop_en();
    chk("t6_class_idx_cleared", class_idx, 0);
    run_once();
    for (int j = 0; j < 10; j++) chk("t6_score", cap_score[j], 16'h0500);
    chk("t6_class_idx", class_idx, 0);
    drop_en();

    // Maximum positive inputs overflow the 16-bit score.
    for (int k = 0; k < 84; k++) act_mem[k] = 16'h7FFF;
    for (int i = 0; i < 840; i++) w_mem[i] = 16'h7FFF;
    for (int j = 0; j < 10; j++) b_mem[j] = 16'h0000;
    run_model();
`ifdef FC3_SCORE_SAT_EN
    t4_exp = 16'h7FFF;
`else
    t4_exp = 16'hAC00;
`endif
    run_once();
    for (int j = 0; j < 10; j++) chk("t4_score", cap_score[j], t4_exp);
    chk("t4_class_idx", class_idx, 0);
    drop_en();

    // Reset in the middle of neuron 4, then a clean rerun.
    load_test1();
    @(negedge clk);
    en  = 1'b1;
    cyc = 0;
    while (weight_addr != 10'd376 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_rst_point_k", in_read_addr, 40);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t5_mid_rst");
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    run_once();
    check_test1("t5_rerun");
    drop_en();

    // Randomised contents, checked against the model by the monitor.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 84; k++)
        act_mem[k] = (r < 2) ? 16'($urandom_range(0, 511)) : 16'($urandom);
      for (int i = 0; i < 840; i++)
        w_mem[i] = (r < 2) ? 16'($urandom_range(0, 511)) - 16'd256 : 16'($urandom);
      for (int j = 0; j < 10; j++) b_mem[j] = 16'($urandom);
      run_model();
      run_once();
      for (int j = 0; j < 10; j++) chk("rand_score", cap_score[j], exp_score[j]);
      drop_en();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
